// File: rtl/sensor_drain.sv
// sensor_drain: arms the sensor controller, drains its full buffer into data memory
// over a req/gnt port, and keeps unsigned sum/min/max statistics of each run.
module sensor_drain #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int MAW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic [MAW-1:0]   base_addr,
  output logic             sctrl_en,
  output logic             sctrl_clear,
  output logic [AW-1:0]    sctrl_addr,
  input  logic             sctrl_interrupt,
  input  logic [DW-1:0]    sctrl_out,
  output logic             dm_req,
  output logic [MAW-1:0]   dm_addr,
  output logic [DW-1:0]    dm_wdata,
  input  logic             dm_gnt,
  output logic             busy,
  output logic             done,
  output logic [DW+AW-1:0] stat_sum,
  output logic [DW-1:0]    stat_min,
  output logic [DW-1:0]    stat_max
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_DRAIN   = 3'd2,
    S_CLEAR   = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam int SW = DW + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [MAW-1:0] word_addr(input logic [MAW-1:0] base,
                                               input logic [AW-1:0]  idx);
    return base + {{(MAW-AW-2){1'b0}}, idx, 2'b00};
  endfunction

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [MAW-1:0] base_q, base_d;
  logic           cont_q, cont_d;
  logic           abort_q, abort_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [DW-1:0]  min_q, min_d;
  logic [DW-1:0]  max_q, max_d;
  logic [SW-1:0]  stat_sum_q, stat_sum_d;
  logic [DW-1:0]  stat_min_q, stat_min_d;
  logic [DW-1:0]  stat_max_q, stat_max_d;
  logic           sctrl_en_q, sctrl_en_d;
  logic           sctrl_clear_q, sctrl_clear_d;
  logic           dm_req_q, dm_req_d;
  logic [MAW-1:0] dm_addr_q, dm_addr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Next-state, datapath and next-output computation; outputs derive from the next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    cont_d     = cont_q;
    abort_d    = abort_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    stat_sum_d = stat_sum_q;
    stat_min_d = stat_min_q;
    stat_max_d = stat_max_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          base_d = base_addr;
          cont_d = cont;
          idx_d  = '0;
          sum_d  = '0;
          min_d  = '1;
          max_d  = '0;
          if (sctrl_interrupt) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (sctrl_interrupt) begin
          state_d = S_DRAIN;
        end else if (stop) begin
          state_d = S_CLEAR;
          abort_d = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (dm_req_q && dm_gnt) begin
          sum_d = sum_q + {{AW{1'b0}}, sctrl_out};
          if (sctrl_out < min_q) begin
            min_d = sctrl_out;
          end else begin
            min_d = min_q;
          end
          if (sctrl_out > max_q) begin
            max_d = sctrl_out;
          end else begin
            max_d = max_q;
          end
          idx_d = idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_CLEAR: begin
        // Statistics land together with the done pulse so they are valid when it is seen.
        state_d = S_FINISH;
        if (!abort_q) begin
          stat_sum_d = sum_q;
          stat_min_d = min_q;
          stat_max_d = max_q;
        end else begin
          stat_sum_d = stat_sum_q;
          stat_min_d = stat_min_q;
          stat_max_d = stat_max_q;
        end
      end
      S_FINISH: begin
        if (cont_q && !abort_q) begin
          idx_d   = '0;
          sum_d   = '0;
          min_d   = '1;
          max_d   = '0;
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sctrl_en_d    = (state_d == S_COLLECT);
    sctrl_clear_d = (state_d == S_CLEAR);
    dm_req_d      = (state_d == S_DRAIN);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FINISH);
    if (state_d == S_DRAIN) begin
      dm_addr_d = word_addr(base_d, idx_d);
    end else begin
      dm_addr_d = '0;
    end
  end

  // State and registered outputs; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      base_q        <= '0;
      cont_q        <= 1'b0;
      abort_q       <= 1'b0;
      sum_q         <= '0;
      min_q         <= '1;
      max_q         <= '0;
      stat_sum_q    <= '0;
      stat_min_q    <= '1;
      stat_max_q    <= '0;
      sctrl_en_q    <= 1'b0;
      sctrl_clear_q <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      cont_q        <= cont_d;
      abort_q       <= abort_d;
      sum_q         <= sum_d;
      min_q         <= min_d;
      max_q         <= max_d;
      stat_sum_q    <= stat_sum_d;
      stat_min_q    <= stat_min_d;
      stat_max_q    <= stat_max_d;
      sctrl_en_q    <= sctrl_en_d;
      sctrl_clear_q <= sctrl_clear_d;
      dm_req_q      <= dm_req_d;
      dm_addr_q     <= dm_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // The controller read port is combinational, so write data follows it in the same cycle.
  assign dm_wdata    = dm_req_q ? sctrl_out : '0;
  assign sctrl_en    = sctrl_en_q;
  assign sctrl_clear = sctrl_clear_q;
  assign sctrl_addr  = idx_q;
  assign dm_req      = dm_req_q;
  assign dm_addr     = dm_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stat_sum    = stat_sum_q;
  assign stat_min    = stat_min_q;
  assign stat_max    = stat_max_q;

endmodule
